// File: rtl/coco_ioctl_pkg.sv
// Shared definitions for the HPS ioctl upload responder.
//   state_e        : responder FSM states
//   IDX_ROM/CART   : ioctl_index values that map onto the ROM/cartridge store
//   FILL_OOR/ERR   : bytes returned for out-of-range reads and bad index/timeout
//   region_decode  : classifies an (index, offset) pair against the region sizes
package coco_ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_e;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_CART = 8'd1;
  localparam logic [7:0] FILL_OOR = 8'h00;
  localparam logic [7:0] FILL_ERR = 8'hFF;

  typedef struct packed {
    logic known;     // index names a region
    logic in_range;  // offset lies inside that region
    logic is_cart;   // region is the cartridge image (else ROM image)
  } region_t;

  function automatic region_t region_decode(input logic [7:0]  idx,
                                            input logic [24:0] addr,
                                            input logic [24:0] rom_len,
                                            input logic [24:0] cart_len);
    region_t r;
    r.known    = 1'b0;
    r.in_range = 1'b0;
    r.is_cart  = 1'b0;
    if (idx == IDX_ROM) begin
      r.known    = 1'b1;
      r.in_range = (addr < rom_len);
    end else if (idx == IDX_CART) begin
      r.known    = 1'b1;
      r.in_range = (addr < cart_len);
      r.is_cart  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coco_ioctl_upload_if.sv
// Bundle of the HPS ioctl upload strobes and the byte memory port.
//   master : the environment (hps_io drives ioctl_*, the memory arbiter answers)
//   slave  : the upload responder
//   ioctl_upload/index/rd/addr -> responder ; ioctl_din/wait <- responder
//   mem_addr/mem_rd <- responder ; mem_ack/mem_dout -> responder
interface coco_ioctl_upload_if #(
  parameter int unsigned MEM_AW = 21
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [7:0]        mem_dout;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait,
    input  mem_addr, mem_rd,
    output mem_ack, mem_dout
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait,
    output mem_addr, mem_rd,
    input  mem_ack, mem_dout
  );
endinterface

// File: rtl/coco_ioctl_upload.sv
// HPS ioctl upload responder: serves ioctl_rd strobes from the ROM/cartridge
// store through a variable-latency byte port, stalling the HPS with ioctl_wait.
//   clk_sys, reset  : core clock, synchronous active-high reset
//   bus (slave)     : ioctl upload strobes and the memory byte port
//   upload_active   : ioctl_upload delayed one cycle
//   upload_bytes    : bytes served this session (saturating)
//   err_timeout     : sticky, a fetch ran out of time waiting for mem_ack
module coco_ioctl_upload
  import coco_ioctl_pkg::*;
#(
  parameter int unsigned       MEM_AW    = 21,
  parameter logic [MEM_AW-1:0] ROM_BASE  = '0,
  parameter logic [24:0]       ROM_LEN   = 25'h10000,
  parameter logic [MEM_AW-1:0] CART_BASE = MEM_AW'(21'h010000),
  parameter logic [24:0]       CART_LEN  = 25'h08000,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic                clk_sys,
  input  logic                reset,
  coco_ioctl_upload_if.slave  bus,
  output logic                upload_active,
  output logic [24:0]         upload_bytes,
  output logic                err_timeout
);

  localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              active_q;
  logic [24:0]       bytes_q, bytes_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  region_t           dec;
  logic              strobe;

  assign strobe = bus.ioctl_rd & bus.ioctl_upload;
  assign dec    = region_decode(bus.ioctl_index, bus.ioctl_addr, ROM_LEN, CART_LEN);

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    bytes_d = bytes_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          if (!dec.known) begin
            din_d   = FILL_ERR;
            state_d = DONE;
          end else if (!dec.in_range) begin
            din_d   = FILL_OOR;
            state_d = DONE;
          end else begin
            addr_d  = (dec.is_cart ? CART_BASE : ROM_BASE) + bus.ioctl_addr[MEM_AW-1:0];
            rd_d    = 1'b1;
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // Session end wins over a coincident ack: the fetch is simply dropped.
        if (!bus.ioctl_upload) begin
          rd_d    = 1'b0;
          state_d = IDLE;
        end else if (bus.mem_ack) begin
          din_d   = bus.mem_dout;
          rd_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          din_d   = FILL_ERR;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bytes_q != '1) bytes_d = bytes_q + 25'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.ioctl_upload && !active_q) begin
      bytes_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      din_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      active_q <= 1'b0;
      bytes_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      active_q <= bus.ioctl_upload;
      bytes_q  <= bytes_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ioctl_wait = strobe | (state_q != IDLE);
  assign bus.ioctl_din  = din_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = rd_q;
  assign upload_active  = active_q;
  assign upload_bytes   = bytes_q;
  assign err_timeout    = err_q;

endmodule
